// File: rtl/axis_uart_pkg.sv
// rtl/axis_uart_pkg.sv - shared state encoding and defaults for the AXIS UART transmitter
package axis_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_STOP_BITS    = 1;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter, pulses tick on the last clk of each UART bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt;

    // Dropping en restarts the bit period so every frame starts phase-aligned.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            baud_cnt <= '0;
        end else if (baud_cnt == CNT_MAX) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign tick = en && (baud_cnt == CNT_MAX);

endmodule

// File: rtl/axis_uart_tx.sv
// rtl/axis_uart_tx.sv - AXI-Stream byte sink serialising each beat onto a UART TX line
module axis_uart_tx
    import axis_uart_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_axis_data,
    input  logic             s_axis_valid,
    input  logic             s_axis_last,
    output logic             s_axis_ready,
    output logic             uart_tx,
    output logic             busy,
    output logic             last_done
);

    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    state_t             state;
    logic [WIDTH-1:0]   shift_reg;
    logic               last_reg;
    logic [BIT_W-1:0]   bit_idx;
    logic [STOP_W-1:0]  stop_idx;
    logic               tick;

    assign s_axis_ready = (state == IDLE) && !rst;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .en  (state != IDLE),
        .tick(tick)
    );

    // uart_tx is registered from the current state, so the line trails the FSM by one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            last_reg  <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= '0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            last_done <= 1'b0;
        end else begin
            last_done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (s_axis_valid) begin
                        shift_reg <= s_axis_data;
                        last_reg  <= s_axis_last;
                        bit_idx   <= '0;
                        stop_idx  <= '0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    uart_tx <= 1'b0;
                    if (tick) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    uart_tx <= shift_reg[0];
                    if (tick) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    uart_tx <= 1'b1;
                    if (tick) begin
                        if (stop_idx == STOP_LAST) begin
                            stop_idx  <= '0;
                            busy      <= 1'b0;
                            last_done <= last_reg;
                            state     <= IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb/tb_axis_uart_tx.sv - directed bench for axis_uart_tx with CLKS_PER_BIT=4
module tb_axis_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       tx;
    logic       busy;
    logic       ld;

    logic [7:0] s_data2;
    logic       s_valid2;
    logic       s_last2;
    logic       s_ready2;
    logic       tx2;
    logic       busy2;
    logic       ld2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ld_total = 0;

    axis_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst),
        .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_last(s_last),
        .s_axis_ready(s_ready), .uart_tx(tx), .busy(busy), .last_done(ld)
    );

    axis_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst),
        .s_axis_data(s_data2), .s_axis_valid(s_valid2), .s_axis_last(s_last2),
        .s_axis_ready(s_ready2), .uart_tx(tx2), .busy(busy2), .last_done(ld2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (ld === 1'b1) ld_total++;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte and return at the first negedge after the accept edge (sample 0).
    task automatic start_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", (n < 200), 1);
        @(negedge clk);
    endtask

    // Called at sample 0; walks samples 0..40 of a 41-cycle window.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic l);
        int tx_bad = 0, busy_n = 0, ld_n = 0, ld_at = -1, rdy_n = 0;
        logic [7:0] dec = 8'h00;
        logic exp_tx;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 1 && k <= 4) exp_tx = 1'b0;
            else if (k >= 5 && k <= 36) exp_tx = d[(k-5)/4];
            else exp_tx = 1'b1;
            if (tx !== exp_tx) tx_bad++;
            if (k >= 5 && k <= 36 && ((k - 5) % 4) == 2) dec[(k-5)/4] = tx;
            if (busy === 1'b1) busy_n++;
            if (ld === 1'b1) begin ld_n++; ld_at = k; end
            if (s_ready === 1'b1) rdy_n++;
        end
        check({tag, " tx_wave_errs"}, tx_bad, 0);
        check({tag, " decoded"}, dec, d);
        check({tag, " busy_cycles"}, busy_n, 40);
        check({tag, " last_done_count"}, ld_n, l ? 1 : 0);
        if (l) check({tag, " last_done_at"}, ld_at, 40);
        check({tag, " ready_cycles"}, rdy_n, 1);
    endtask

    logic [7:0] msg [6] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};

    initial begin
        int tprev, ld_before;
        int busy_n, low_n, stop_hi, ld_n;
        rst = 1'b1; s_data = 8'hAA; s_valid = 1'b1; s_last = 1'b1;
        s_data2 = 8'h00; s_valid2 = 1'b0; s_last2 = 1'b0;

        // reset holds off transfers
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst ready", s_ready, 0);
            check("rst tx", tx, 1);
            check("rst busy", busy, 0);
        end
        check("rst last_done", ld, 0);
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("post_rst ready", s_ready, 1);
        check("post_rst busy", busy, 0);

        // single byte 0x55 with last
        start_byte(8'h55, 1'b1);
        s_valid = 1'b0;
        expect_frame("t2_55", 8'h55, 1'b1);

        // HELLO\n back to back
        ld_before = ld_total;
        start_byte(msg[0], 1'b0);
        tprev = cyc;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check("t3 period", cyc - tprev, 41);
                tprev = cyc;
            end
            if (i < 5) begin
                s_data = msg[i+1];
                s_last = (i + 1 == 5);
            end else begin
                s_valid = 1'b0;
            end
            expect_frame("t3_hello", msg[i], (i == 5));
        end
        check("t3 last_done_total", ld_total - ld_before, 1);

        // data changes while busy; latched byte goes out first
        start_byte(8'h3C, 1'b0);
        s_data = 8'hC3;
        s_last = 1'b1;
        expect_frame("t4_latched", 8'h3C, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        expect_frame("t4_next", 8'hC3, 1'b1);

        // reset mid-frame at the start of data bit 3
        start_byte(8'hA3, 1'b1);
        s_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5 tx", tx, 1);
        check("t5 busy", busy, 0);
        check("t5 last_done", ld, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5 ready", s_ready, 1);
        check("t5 tx_idle", tx, 1);
        start_byte(8'h0F, 1'b0);
        s_valid = 1'b0;
        expect_frame("t5_0f", 8'h0F, 1'b0);

        // two stop bits
        s_data2 = 8'hFF; s_last2 = 1'b0; s_valid2 = 1'b1;
        check("t6 ready", s_ready2, 1);
        @(negedge clk);
        s_valid2 = 1'b0;
        busy_n = 0; low_n = 0; stop_hi = 0; ld_n = 0;
        for (int k = 0; k <= 44; k++) begin
            if (k > 0) @(negedge clk);
            if (busy2 === 1'b1) busy_n++;
            if (tx2 === 1'b0) low_n++;
            if (k >= 37 && tx2 === 1'b1) stop_hi++;
            if (ld2 === 1'b1) ld_n++;
            if (k == 1) check("t6 start_low", tx2, 0);
            if (k == 43) check("t6 busy_last", busy2, 1);
        end
        check("t6 busy_cycles", busy_n, 44);
        check("t6 low_cycles", low_n, 4);
        check("t6 stop_high", stop_hi, 8);
        check("t6 last_done", ld_n, 0);
        check("t6 ready_end", s_ready2, 1);
        check("t6 busy_end", busy2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
